// File: rtl/mc_controller.sv
// Control FSM for a multicycle RV32I-subset core sharing one ALU and one memory.
// Drives ALU opcode, datapath selects and write enables; resolves branches from ALU flags.
module mc_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic             zero,
  input  logic             neg,
  output logic [2:0]       alu_ctrl,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       result_src,
  output logic [2:0]       imm_src,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             mem_write,
  output logic             reg_write,
  output logic             illegal,
  output logic             retire,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, EXEC_I,
    ALU_WB, BRANCH, JALR, JAL, LUI, ILLEGAL
  } state_t;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;

  state_t           state_q, state_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       alu_fn;
  logic             alu_fn_ok;

  // Shared R/I funct3 decode; the SUB variant only exists for register-register ops.
  always_comb begin
    alu_fn    = ALU_ADD;
    alu_fn_ok = 1'b1;
    case (funct3)
      3'b000:  alu_fn = (state_q == EXEC_R && funct7_5) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_fn = ALU_SLT;
      3'b011:  alu_fn = ALU_SLTU;
      3'b100:  alu_fn = ALU_XOR;
      3'b110:  alu_fn = ALU_OR;
      3'b111:  alu_fn = ALU_AND;
      default: alu_fn_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    alu_ctrl   = ALU_ADD;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    retire     = 1'b0;
    case (op)
      7'b0100011: imm_src = 3'b001;
      7'b1100011: imm_src = 3'b010;
      7'b1101111: imm_src = 3'b011;
      7'b0110111: imm_src = 3'b100;
      default:    imm_src = 3'b000;
    endcase

    case (state_q)
      FETCH: begin
        ir_write   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_write   = 1'b1;
        state_d    = DECODE;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          7'b0000011, 7'b0100011: state_d = MEM_ADR;
          7'b0110011:             state_d = EXEC_R;
          7'b0010011:             state_d = EXEC_I;
          7'b1100011:             state_d = BRANCH;
          7'b1101111:             state_d = JAL;
          7'b1100111:             state_d = JALR;
          7'b0110111:             state_d = LUI;
          default:                state_d = ILLEGAL;
        endcase
      end
      MEM_ADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (op == 7'b0000011) ? MEM_READ : MEM_WRITE;
      end
      MEM_READ: begin
        adr_src = 1'b1;
        state_d = MEM_WB;
      end
      MEM_WB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_d    = FETCH;
      end
      MEM_WRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        retire    = 1'b1;
        state_d   = FETCH;
      end
      EXEC_R, EXEC_I: begin
        alu_src_a = 2'b10;
        alu_src_b = (state_q == EXEC_I) ? 2'b01 : 2'b00;
        if (alu_fn_ok) begin
          alu_ctrl = alu_fn;
          state_d  = ALU_WB;
        end else begin
          state_d  = ILLEGAL;
        end
      end
      ALU_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = FETCH;
      end
      BRANCH: begin
        alu_src_a = 2'b10;
        alu_ctrl  = ALU_SUB;
        retire    = 1'b1;
        state_d   = FETCH;
        // Condition comes straight off this cycle's SUB flags; overflow is not corrected.
        case (funct3)
          3'b000: pc_write = zero;
          3'b001: pc_write = !zero;
          3'b100: pc_write = neg;
          3'b101: pc_write = !neg;
          default: begin
            retire  = 1'b0;
            state_d = ILLEGAL;
          end
        endcase
      end
      JALR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = JAL;
      end
      JAL: begin
        pc_write  = 1'b1;
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        state_d   = ALU_WB;
      end
      LUI: begin
        result_src = 2'b11;
        imm_src    = 3'b100;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_d    = FETCH;
      end
      default: state_d = ILLEGAL;
    endcase

    // Reset abandons whatever is in flight without any writes.
    if (rst) begin
      alu_ctrl   = ALU_ADD;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      result_src = 2'b00;
      imm_src    = 3'b000;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      retire     = 1'b0;
    end

    illegal_d = illegal_q | (state_d == ILLEGAL);
    cnt_d     = cnt_q + CNT_W'(retire);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  assign illegal     = illegal_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: per-instruction expected control sequences built from
// the instruction-level behaviour, compared cycle by cycle with randomized programs.
module tb_mc_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7_5, zero, neg;
  logic [2:0]  alu_ctrl, imm_src;
  logic [1:0]  alu_src_a, alu_src_b, result_src;
  logic        adr_src, ir_write, pc_write, mem_write, reg_write, illegal, retire;
  logic [31:0] instr_count;

  mc_controller #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .neg(neg), .alu_ctrl(alu_ctrl), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .result_src(result_src), .imm_src(imm_src),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write),
    .mem_write(mem_write), .reg_write(reg_write), .illegal(illegal),
    .retire(retire), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] OP_LW = 7'h03, OP_SW = 7'h23, OP_R = 7'h33, OP_I = 7'h13,
                         OP_BR = 7'h63, OP_JAL = 7'h6F, OP_JALR = 7'h67, OP_LUI = 7'h37;

  int tests_run = 0;
  int tests_failed = 0;
  int exp_cnt = 0;
  logic [18:0] obs;
  logic [18:0] seq[$];

  assign obs = {alu_ctrl, alu_src_a, alu_src_b, result_src, imm_src,
                adr_src, ir_write, pc_write, mem_write, reg_write, retire};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [18:0] v(input int ac, a, b, rs, imm, adr, irw, pcw, mw, rw, ret);
    v = {3'(ac), 2'(a), 2'(b), 2'(rs), 3'(imm), 1'(adr), 1'(irw), 1'(pcw), 1'(mw), 1'(rw), 1'(ret)};
  endfunction

  function automatic int imm_of(input logic [6:0] o);
    case (o)
      OP_SW:   return 1;
      OP_BR:   return 2;
      OP_JAL:  return 3;
      OP_LUI:  return 4;
      default: return 0;
    endcase
  endfunction

  // RISC-V funct3 -> ALU opcode for arithmetic instructions.
  function automatic int alu_of(input logic [2:0] f3, input logic sub);
    case (f3)
      3'd0:    return sub ? 1 : 0;
      3'd2:    return 5;
      3'd3:    return 6;
      3'd4:    return 4;
      3'd6:    return 3;
      default: return 2;
    endcase
  endfunction

  function automatic logic br_taken(input logic [2:0] f3, input logic z, input logic n);
    case (f3)
      3'd0:    return z;
      3'd1:    return !z;
      3'd4:    return n;
      default: return !n;
    endcase
  endfunction

  // Expected output for every cycle of one legal instruction, in order.
  task automatic build(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                       input logic z, input logic n);
    int im;
    logic [18:0] wb;
    im = imm_of(o);
    wb = v(0, 0, 0, 0, im, 0, 0, 0, 0, 1, 1);
    seq.delete();
    seq.push_back(v(0, 0, 2, 2, im, 0, 1, 1, 0, 0, 0));
    seq.push_back(v(0, 1, 1, 0, im, 0, 0, 0, 0, 0, 0));
    case (o)
      OP_R:  begin seq.push_back(v(alu_of(f3, f7), 2, 0, 0, im, 0, 0, 0, 0, 0, 0)); seq.push_back(wb); end
      OP_I:  begin seq.push_back(v(alu_of(f3, 1'b0), 2, 1, 0, im, 0, 0, 0, 0, 0, 0)); seq.push_back(wb); end
      OP_LW: begin
        seq.push_back(v(0, 2, 1, 0, im, 0, 0, 0, 0, 0, 0));
        seq.push_back(v(0, 0, 0, 0, im, 1, 0, 0, 0, 0, 0));
        seq.push_back(v(0, 0, 0, 1, im, 0, 0, 0, 0, 1, 1));
      end
      OP_SW: begin
        seq.push_back(v(0, 2, 1, 0, im, 0, 0, 0, 0, 0, 0));
        seq.push_back(v(0, 0, 0, 0, im, 1, 0, 0, 1, 0, 1));
      end
      OP_BR:  seq.push_back(v(1, 2, 0, 0, im, 0, 0, br_taken(f3, z, n), 0, 0, 1));
      OP_JAL: begin seq.push_back(v(0, 1, 2, 0, im, 0, 0, 1, 0, 0, 0)); seq.push_back(wb); end
      OP_JALR: begin
        seq.push_back(v(0, 2, 1, 0, im, 0, 0, 0, 0, 0, 0));
        seq.push_back(v(0, 1, 2, 0, im, 0, 0, 1, 0, 0, 0));
        seq.push_back(wb);
      end
      default: seq.push_back(v(0, 0, 0, 3, 4, 0, 0, 0, 0, 1, 1));
    endcase
  endtask

  task automatic run_instr(input string tag, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input logic z, input logic n);
    build(o, f3, f7, z, n);
    for (int c = 0; c < seq.size(); c++) begin
      @(negedge clk);
      if (c == 0) begin op = o; funct3 = f3; funct7_5 = f7; zero = z; neg = n; end
      #1;
      check($sformatf("%s.c%0d", tag, c), 64'(obs), 64'(seq[c]));
      check($sformatf("%s.cnt%0d", tag, c), 64'(instr_count), 64'(exp_cnt));
      check($sformatf("%s.ill%0d", tag, c), 64'(illegal), 64'd0);
      if (seq[c][0]) exp_cnt++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst.outs", 64'(obs), 64'd0);
    check("rst.cnt", 64'(instr_count), 64'd0);
    check("rst.ill", 64'(illegal), 64'd0);
    exp_cnt = 0;
    rst = 1'b0;
  endtask

  initial begin
    logic [2:0] alu_f3[6];
    logic [2:0] br_f3[4];
    logic [2:0] f3;
    logic [6:0] o;
    alu_f3 = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7};
    br_f3  = '{3'd0, 3'd1, 3'd4, 3'd5};
    op = OP_R; funct3 = 3'd0; funct7_5 = 1'b0; zero = 1'b0; neg = 1'b0;
    do_reset();

    run_instr("add", OP_R, 3'd0, 1'b0, 1'b0, 1'b0);
    run_instr("sub", OP_R, 3'd0, 1'b1, 1'b0, 1'b0);
    run_instr("beq_t", OP_BR, 3'd0, 1'b0, 1'b1, 1'b0);
    run_instr("beq_n", OP_BR, 3'd0, 1'b0, 1'b0, 1'b0);
    run_instr("bge_n", OP_BR, 3'd5, 1'b0, 1'b0, 1'b1);
    run_instr("lw", OP_LW, 3'd2, 1'b0, 1'b0, 1'b0);
    run_instr("sw", OP_SW, 3'd2, 1'b0, 1'b0, 1'b0);
    run_instr("jalr", OP_JALR, 3'd0, 1'b0, 1'b0, 1'b0);
    run_instr("jal", OP_JAL, 3'd0, 1'b0, 1'b0, 1'b0);
    run_instr("lui", OP_LUI, 3'd0, 1'b0, 1'b0, 1'b0);
    run_instr("addi_f7", OP_I, 3'd0, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 7))
        0: begin o = OP_R;    f3 = alu_f3[$urandom_range(0, 5)]; end
        1: begin o = OP_I;    f3 = alu_f3[$urandom_range(0, 5)]; end
        2: begin o = OP_LW;   f3 = 3'd2; end
        3: begin o = OP_SW;   f3 = 3'd2; end
        4: begin o = OP_BR;   f3 = br_f3[$urandom_range(0, 3)]; end
        5: begin o = OP_JAL;  f3 = 3'($urandom_range(0, 7)); end
        6: begin o = OP_JALR; f3 = 3'd0; end
        default: begin o = OP_LUI; f3 = 3'($urandom_range(0, 7)); end
      endcase
      run_instr($sformatf("rnd%0d", i), o, f3, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Unsupported opcode: fetch and decode, then parked with the sticky flag up.
    run_instr("pre_ill", OP_LUI, 3'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); op = 7'h7F; #1;
    check("ill.fetch", 64'(obs), 64'(v(0, 0, 2, 2, 0, 0, 1, 1, 0, 0, 0)));
    @(negedge clk); #1;
    check("ill.decode", 64'(obs), 64'(v(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0)));
    check("ill.decode_flag", 64'(illegal), 64'd0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      check($sformatf("ill.outs%0d", c), 64'(obs), 64'd0);
      check($sformatf("ill.flag%0d", c), 64'(illegal), 64'd1);
      check($sformatf("ill.cnt%0d", c), 64'(instr_count), 64'(exp_cnt));
    end
    do_reset();

    // Reset arriving during MEM_READ of a load abandons it.
    build(OP_LW, 3'd2, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c == 0) begin op = OP_LW; funct3 = 3'd2; end
      #1;
      check($sformatf("abort.c%0d", c), 64'(obs), 64'(seq[c]));
    end
    @(negedge clk);
    check("abort.mem_read", 64'(obs), 64'(seq[3]));
    rst = 1'b1; #1;
    check("abort.outs", 64'(obs), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    check("abort.fetch", 64'(obs), 64'(seq[0]));
    check("abort.cnt", 64'(instr_count), 64'd0);
    check("abort.ill", 64'(illegal), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multicycle RV32I-subset control FSM that sits directly upstream of the 32-bit ALU.
- Drives the ALU opcode and the datapath mux selects and write enables, and consumes the ALU `zero`/`neg` flags to resolve branches.
- Turns the single-cycle datapath into a shared-ALU multicycle core: one memory, one ALU, with registered IR, A, B, ALUOut and MDR.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- op  in  7  IR[6:0].
- funct3  in  3  IR[14:12].
- funct7_5  in  1  IR[30].
- zero  in  1  ALU zero flag (current cycle).
- neg  in  1  ALU result MSB (current cycle).
- alu_ctrl  out  3  ALU opc: ADD 000, SUB 001, AND 010, OR 011, XOR 100, SLT 101, SLTU 110.
- alu_src_a  out  2  00 PC, 01 oldPC, 10 A reg.
- alu_src_b  out  2  00 B reg, 01 imm, 10 const 4.
- result_src  out  2  00 ALUOut reg, 01 MDR, 10 ALU result direct, 11 imm.
- imm_src  out  3  000 I, 001 S, 010 B, 011 J, 100 U.
- adr_src  out  1  0 PC, 1 ALUOut.
- ir_write  out  1  IR and oldPC load.
- pc_write  out  1  PC load from result bus.
- mem_write  out  1  memory store.
- reg_write  out  1  register file write of rd.
- illegal  out  1  sticky unsupported-instruction flag.
- retire  out  1  one-cycle pulse on the final cycle of each instruction.
- instr_count  out  CNT_W  retired-instruction count, wraps modulo 2^CNT_W.

Behaviour:
- Reset:
  - rst is sampled at clk. While high: state<=FETCH, instr_count<=0, illegal<=0.
  - All enables (ir_write, pc_write, mem_write, reg_write, retire) are forced to 0 and all selects to 0 (alu_ctrl=ADD).
  - Reset mid-instruction abandons the instruction without writes.
- Default for any state: enables 0, selects 0, alu_ctrl ADD, imm_src decoded from op (I for unlisted opcodes).
- FETCH: adr_src=0, ir_write=1, a=00, b=10, ADD, result_src=10, pc_write=1 -> DECODE.
- DECODE: a=01, b=01, ADD (ALUOut<=oldPC+imm) -> next state by op:
  - 0000011 or 0100011 -> MEM_ADR
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 -> LUI
  - otherwise -> ILLEGAL
- MEM_ADR: a=10, b=01, ADD -> MEM_READ (lw) or MEM_WRITE (sw).
- MEM_READ: adr_src=1 -> MEM_WB.
- MEM_WB: result_src=01, reg_write, retire -> FETCH.
- MEM_WRITE: adr_src=1, mem_write, retire -> FETCH.
- EXEC_R: a=10, b=00, alu_ctrl from funct3 -> ALU_WB:
  - 000 -> ADD, or SUB if funct7_5=1
  - 010 -> SLT
  - 011 -> SLTU
  - 100 -> XOR
  - 110 -> OR
  - 111 -> AND
  - 001/101 -> ILLEGAL
- EXEC_I: a=10, b=01, same decode except funct3=000 is always ADD; 001/101 -> ILLEGAL; otherwise -> ALU_WB.
- ALU_WB: result_src=00, reg_write, retire -> FETCH.
- BRANCH: a=10, b=00, SUB, result_src=00, retire -> FETCH.
  - pc_write (Mealy, same cycle): beq `zero`; bne `!zero`; blt `neg`; bge `!neg`.
  - Other funct3 -> ILLEGAL, no pc_write, no retire.
  - blt/bge use the SUB sign only; signed overflow is not corrected.
- JALR: a=10, b=01, ADD (ALUOut<=rs1+imm) -> JAL. Bit 0 of the target is not cleared here.
- JAL: result_src=00, pc_write (PC<=ALUOut); a=01, b=10, ADD (ALUOut<=oldPC+4) -> ALU_WB.
- LUI: result_src=11, imm_src=100, reg_write, retire -> LUI goes to FETCH.
- ILLEGAL: illegal=1; all enables 0; stays until rst.
- Latency in cycles: R/I-ALU 4, lw 5, sw 4, branch 3, lui 3, jal 4, jalr 5. retire is asserted only on the last cycle.
- instr_count increments on each retire cycle.

Test Plan:
- Reset: hold rst 2 cycles then release -> first cycle has ir_write=1, pc_write=1, alu_src_b=10, instr_count=0, illegal=0.
- add (op=0110011, f3=000, f7_5=0) -> states FETCH, DECODE, EXEC_R (alu_ctrl=000), ALU_WB (reg_write=1, retire=1); with f7_5=1, EXEC_R gives alu_ctrl=001; instr_count 0->1.
- beq with zero=1 -> BRANCH cycle has alu_ctrl=001 and pc_write=1; repeat with zero=0 -> pc_write=0; bge with neg=1 -> pc_write=0; both take 3 cycles.
- lw then sw -> lw: 5 cycles, MEM_WB has result_src=01 and reg_write; sw: 4 cycles, MEM_WRITE has adr_src=1 and mem_write=1, reg_write=0.
- jalr -> JALR (a=10, b=01), then JAL (pc_write=1, result_src=00), then ALU_WB (reg_write=1); total 5 cycles.
- op=1111111 -> illegal=1 from the cycle after DECODE, no enables for 10 cycles; assert rst mid-MEM_READ of a lw -> no reg_write, next cycle is FETCH.
